// File: rtl/wall_renderer.sv
// wall_renderer: erases the previous wall strip, then draws the new strip
// with a hole, one pixel per cycle, into a SCREEN_W x SCREEN_H frame buffer.
module wall_renderer #(
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned WALL_W      = 4,
  parameter int unsigned HOLE_H      = 50,
  parameter logic [2:0]  WALL_COLOUR = 3'b010,
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter logic [7:0]  WALL_START  = 8'd160
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] wall_x,
  input  logic [6:0] hole_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (WALL_W > 1) ? $clog2(WALL_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [6:0]     row_q, row_d;
  logic [7:0]     prev_x_q, prev_x_d;
  logic [7:0]     cur_x_q, cur_x_d;
  logic [6:0]     cur_hole_q, cur_hole_d;

  logic           last_row;
  logic           last_col;
  logic [8:0]     col_sum;
  logic [7:0]     hole_end;
  logic           in_hole;
  logic           visible;

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      prev_x_q   <= WALL_START;
      cur_x_q    <= '0;
      cur_hole_q <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      prev_x_q   <= prev_x_d;
      cur_x_q    <= cur_x_d;
      cur_hole_q <= cur_hole_d;
    end
  end

  assign last_row = (row_q == 7'(SCREEN_H - 1));
  assign last_col = (col_q == CW'(WALL_W - 1));

  // Next-state: sequencing and column-major scan counters
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    prev_x_d   = prev_x_q;
    cur_x_d    = cur_x_q;
    cur_hole_d = cur_hole_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_x_d    = wall_x;
          cur_hole_d = hole_y;
          col_d      = '0;
          row_d      = '0;
          state_d    = S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        if (last_row) begin
          row_d = '0;
          if (last_col) begin
            col_d   = '0;
            state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DONE: begin
        prev_x_d = cur_x_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sum kept 9-bit so a wall near the right edge never wraps back on-screen;
  // hole end kept 8-bit so a low hole truncates instead of wrapping to row 0.
  assign col_sum  = {1'b0, (state_q == S_DRAW) ? cur_x_q : prev_x_q} + 9'(col_q);
  assign hole_end = {1'b0, cur_hole_q} + 8'(HOLE_H);
  assign in_hole  = (row_q >= cur_hole_q) && ({1'b0, row_q} < hole_end);
  assign visible  = (col_sum < 9'(SCREEN_W));

  // Pixel outputs decoded from registered state only
  always_comb begin
    vga_x  = '0;
    vga_y  = '0;
    colour = '0;
    plot   = 1'b0;
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    unique case (state_q)
      S_ERASE: begin
        vga_x  = col_sum[7:0];
        vga_y  = row_q;
        colour = BG_COLOUR;
        plot   = visible;
      end
      S_DRAW: begin
        vga_x  = col_sum[7:0];
        vga_y  = row_q;
        colour = WALL_COLOUR;
        plot   = visible && !in_hole;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wall_renderer.sv
// Directed bench for wall_renderer: full renders checked pixel by pixel
// against a scan model, plus hand-computed plot counts and done timing.
module tb_wall_renderer;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] wall_x;
  logic [6:0] hole_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  int checks;
  int failures;
  int prev_model;

  wall_renderer dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .wall_x (wall_x),
    .hole_y (hole_y),
    .vga_x  (vga_x),
    .vga_y  (vga_y),
    .colour (colour),
    .plot   (plot),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One full render; returns per-phase plot counts, the cycle done was seen,
  // and the number of cycles whose outputs disagreed with the scan model.
  // A second start is pulsed at cycle inj (0 = none) to exercise busy-ignore.
  task automatic render(input int wx, input int hy, input int inj,
                        output int erase_plots, output int draw_plots,
                        output int done_cyc, output int errs);
    int i, ph, j, col, row, base, sum;
    bit ep;
    erase_plots = 0; draw_plots = 0; done_cyc = 0; errs = 0;
    @(negedge clk);
    wall_x = 8'(wx);
    hole_y = 7'(hy);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wall_x = 8'hA5;
    hole_y = 7'h55;
    for (int k = 1; k <= 961; k++) begin
      @(negedge clk);
      if (done) done_cyc = k;
      if (k == 961) begin
        if (!busy || !done || plot) errs++;
      end else begin
        i    = k - 1;
        ph   = i / 480;
        j    = i % 480;
        col  = j / 120;
        row  = j % 120;
        base = (ph == 1) ? wx : prev_model;
        sum  = base + col;
        ep   = (sum < 160) && !((ph == 1) && (row >= hy) && (row < hy + 50));
        if (!busy || done || (plot != ep)) errs++;
        if (plot) begin
          if (ph == 0) erase_plots++; else draw_plots++;
          if ((vga_x != 8'(sum)) || (vga_y != 7'(row)) ||
              (colour != ((ph == 1) ? 3'b010 : 3'b000))) errs++;
        end
      end
      if (k == inj) begin
        wall_x = 8'd80; hole_y = 7'd5; start = 1'b1;
      end else if (k == inj + 1) begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    if (busy || done || plot) errs++;
    prev_model = wx;
  endtask

  int ep_n, dp_n, dc, er;

  initial begin
    checks = 0; failures = 0; prev_model = 160;
    resetn = 1'b0; start = 1'b0; wall_x = '0; hole_y = '0;
    #12;
    check("rst_plot",   int'(plot),   0);
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_vga_x",  int'(vga_x),  0);
    check("rst_vga_y",  int'(vga_y),  0);
    check("rst_colour", int'(colour), 0);
    resetn = 1'b1;

    // 1: first render, erase of off-screen reset position is silent
    render(100, 30, 0, ep_n, dp_n, dc, er);
    check("t1_erase_plots", ep_n, 0);
    check("t1_draw_plots",  dp_n, 280);
    check("t1_done_cyc",    dc,   961);
    check("t1_pix_err",     er,   0);

    // 2: erase old wall at 100..103 fully, draw at 96..99
    render(96, 30, 0, ep_n, dp_n, dc, er);
    check("t2_erase_plots", ep_n, 480);
    check("t2_draw_plots",  dp_n, 280);
    check("t2_pix_err",     er,   0);

    // 3: right edge, only columns 158/159 visible
    render(158, 30, 0, ep_n, dp_n, dc, er);
    check("t3_erase_plots", ep_n, 480);
    check("t3_draw_plots",  dp_n, 140);
    check("t3_done_cyc",    dc,   961);
    check("t3_pix_err",     er,   0);

    // 4: underflowed position, nothing drawn
    render(252, 30, 0, ep_n, dp_n, dc, er);
    check("t4_erase_plots", ep_n, 240);
    check("t4_draw_plots",  dp_n, 0);
    check("t4_done_cyc",    dc,   961);
    check("t4_pix_err",     er,   0);

    // 5: hole past the bottom truncates; erase of 252 is silent
    render(20, 100, 0, ep_n, dp_n, dc, er);
    check("t5_erase_plots", ep_n, 0);
    check("t5_draw_plots",  dp_n, 400);
    check("t5_pix_err",     er,   0);

    // 6a: start while busy is ignored
    render(40, 10, 100, ep_n, dp_n, dc, er);
    check("t6_erase_plots", ep_n, 480);
    check("t6_draw_plots",  dp_n, 280);
    check("t6_done_cyc",    dc,   961);
    check("t6_pix_err",     er,   0);

    // 6b: reset mid-DRAW aborts at once
    @(negedge clk);
    wall_x = 8'd60; hole_y = 7'd20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (600) @(negedge clk);
    check("t6_pre_rst_busy", int'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    check("t6_rst_busy",  int'(busy),  0);
    check("t6_rst_plot",  int'(plot),  0);
    check("t6_rst_vga_x", int'(vga_x), 0);
    @(negedge clk);
    resetn = 1'b1;
    prev_model = 160;
    render(10, 0, 0, ep_n, dp_n, dc, er);
    check("t6_post_erase_plots", ep_n, 0);
    check("t6_post_draw_plots",  dp_n, 280);
    check("t6_post_pix_err",     er,   0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1);
  end

endmodule
